// File: rtl/light_package.sv
// Shared light types for the intersection controllers: light colors, the
// controller phase, and a helper that renders one active light into a
// full light vector.
package light_package;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

  // Widest supported intersection; controllers slice the low NUM_CH lights.
  localparam int MAX_CH    = 8;
  localparam int MAX_IDX_W = 3;

  typedef colors [MAX_CH-1:0] light_vec_t;

  // All lights red except channel idx, which shows the color of the phase.
  // ALL_RED leaves every light red regardless of idx.
  function automatic light_vec_t colors_onehot(input logic [MAX_IDX_W-1:0] idx,
                                               input phase_t ph);
    light_vec_t v;
    for (int i = 0; i < MAX_CH; i++) begin
      v[i] = red;
    end
    case (ph)
      GREEN:   v[idx] = green;
      YELLOW:  v[idx] = yellow;
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: returns the first requesting channel
// found scanning upward from ptr with wrap-around.
module rr_arbiter_n #(
  parameter  int NUM_CH = 3,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  // Scan offsets from the highest down so the smallest offset from ptr wins.
  always_comb begin
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      if (req[IDX_W'(j)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// NUM_CH-approach intersection controller. A single phase FSM cycles
// ALL_RED -> GREEN -> YELLOW -> ALL_RED, granting one channel at a time in
// round-robin order. force_red ends a green early and blocks new grants.
// All outputs are registered; the phase output doubles as the FSM state.
module traffic_light_controller_n
  import light_package::*;
#(
  parameter  int NUM_CH     = 3,
  parameter  int GREEN_MIN  = 3,
  parameter  int GREEN_MAX  = 5,
  parameter  int YELLOW_CYC = 2,
  parameter  int CLEAR_CYC  = 1,
  localparam int IDX_W      = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       sensors,
  input  logic                    force_red,
  output colors [NUM_CH-1:0]      lights,
  output logic [IDX_W-1:0]        active_ch,
  output phase_t                  phase
);

  localparam int GW = $clog2(GREEN_MAX + 1);
  localparam int YW = $clog2(YELLOW_CYC + 1);
  localparam int CW = $clog2(CLEAR_CYC + 1);

  localparam logic [GW-1:0]    G_MIN    = GW'(GREEN_MIN);
  localparam logic [GW-1:0]    G_MAX    = GW'(GREEN_MAX);
  localparam logic [YW-1:0]    Y_CYC    = YW'(YELLOW_CYC);
  localparam logic [CW-1:0]    C_CYC    = CW'(CLEAR_CYC);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  typedef colors [NUM_CH-1:0] ch_lights_t;

  // Light vector for this intersection's width.
  function automatic ch_lights_t light_vec(input logic [IDX_W-1:0] idx,
                                           input phase_t ph);
    light_vec_t full;
    full = colors_onehot(MAX_IDX_W'(idx), ph);
    return full[NUM_CH-1:0];
  endfunction

  phase_t           phase_q;
  logic [IDX_W-1:0] active_q;
  logic [IDX_W-1:0] ptr_q;
  logic [GW-1:0]    green_cnt;
  logic [YW-1:0]    yellow_cnt;
  logic [CW-1:0]    clear_cnt;
  ch_lights_t       lights_q;

  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] own_mask;
  logic              own_req;
  logic              other_req;
  logic              clear_done;
  logic [IDX_W-1:0]  next_ptr;

  rr_arbiter_n #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req         (sensors),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Request views relative to the active channel, clearance status and the
  // pointer value the next ALL_RED will start scanning from.
  always_comb begin
    own_mask   = NUM_CH'(1) << active_q;
    own_req    = |(sensors & own_mask);
    other_req  = |(sensors & ~own_mask);
    clear_done = (clear_cnt >= C_CYC);
    next_ptr   = (active_q == LAST_CH) ? '0 : active_q + 1'b1;
  end

  // Phase FSM with its counters; lights are computed from the next state so
  // they change on the same edge as phase and active_ch.
  // Counters hold "cycles elapsed including the current one", so each is
  // loaded with 1 on phase entry and saturates at its limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= ALL_RED;
      active_q   <= '0;
      ptr_q      <= '0;
      green_cnt  <= '0;
      yellow_cnt <= '0;
      clear_cnt  <= C_CYC;
      lights_q   <= light_vec('0, ALL_RED);
    end else begin
      case (phase_q)
        ALL_RED: begin
          if (clear_done && !force_red && grant_valid) begin
            phase_q   <= GREEN;
            active_q  <= grant_idx;
            green_cnt <= GW'(1);
            lights_q  <= light_vec(grant_idx, GREEN);
          end else if (!clear_done) begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        GREEN: begin
          if (force_red ||
              ((green_cnt >= G_MIN) && !own_req) ||
              ((green_cnt >= G_MAX) && other_req)) begin
            phase_q    <= YELLOW;
            yellow_cnt <= YW'(1);
            lights_q   <= light_vec(active_q, YELLOW);
          end else if (green_cnt < G_MAX) begin
            green_cnt <= green_cnt + 1'b1;
          end
        end
        YELLOW: begin
          if (yellow_cnt >= Y_CYC) begin
            phase_q   <= ALL_RED;
            clear_cnt <= CW'(1);
            ptr_q     <= next_ptr;
            lights_q  <= light_vec(active_q, ALL_RED);
          end else begin
            yellow_cnt <= yellow_cnt + 1'b1;
          end
        end
        default: begin
          phase_q  <= ALL_RED;
          lights_q <= light_vec(active_q, ALL_RED);
        end
      endcase
    end
  end

  assign lights    = lights_q;
  assign active_ch = active_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Directed bench for traffic_light_controller_n. The driver applies one
// input vector per cycle and queues the hand-computed state expected after
// the edge that samples it; the negedge monitor pops and compares.
module tb_traffic_light_controller_n;
  import light_package::*;

  localparam int NUM_CH = 3;
  localparam int IDX_W  = 2;
  localparam int LW     = 2 * NUM_CH;
  localparam int W      = 32 + 2 + IDX_W + LW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_CH-1:0]    sensors = '0;
  logic                 force_red = 1'b0;
  colors [NUM_CH-1:0]   lights;
  logic [IDX_W-1:0]     active_ch;
  phase_t               phase;
  logic [LW-1:0]        lights_bits;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  traffic_light_controller_n #(
    .NUM_CH     (NUM_CH),
    .GREEN_MIN  (3),
    .GREEN_MAX  (5),
    .YELLOW_CYC (2),
    .CLEAR_CYC  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sensors   (sensors),
    .force_red (force_red),
    .lights    (lights),
    .active_ch (active_ch),
    .phase     (phase)
  );

  assign lights_bits = lights;

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected light vector: everything red except channel ch in phase color.
  function automatic logic [LW-1:0] exp_lights(input phase_t ph, input int ch);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == ch && ph == GREEN)  v[2*i +: 2] = 2'd2;
      if (i == ch && ph == YELLOW) v[2*i +: 2] = 2'd1;
    end
    return v;
  endfunction

  // Apply one input vector and queue the state expected after the next edge.
  task automatic step(input logic [NUM_CH-1:0] s, input logic fr,
                      input phase_t ph, input int ch);
    sensors   = s;
    force_red = fr;
    exp_q.push_back({32'(cyc + 1), ph, IDX_W'(ch), exp_lights(ph, ch)});
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the asynchronous all-red state, then
  // release it just after an edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    sensors   = '0;
    force_red = 1'b0;
    #1;
    n_checks++;
    if (phase !== ALL_RED || active_ch !== '0 || lights_bits !== exp_lights(ALL_RED, 0)) begin
      n_fail++;
      $display("FAIL %s: phase=%0d active=%0d lights=%h, required phase=0 active=0 lights=%h",
               name, phase, active_ch, lights_bits, exp_lights(ALL_RED, 0));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: exclusivity invariant every cycle, then scoreboard pops.
  always @(negedge clk) begin
    if (!reset) begin
      int nonred;
      logic [W-1:0] item;
      nonred = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (lights_bits[2*i +: 2] != 2'd0) nonred++;
      end
      n_checks++;
      if (nonred > 1) begin
        n_fail++;
        $display("FAIL exclusive cyc=%0d: %0d non-red lights (%h), required at most 1",
                 cyc, nonred, lights_bits);
      end
      while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= cyc) begin
        item = exp_q.pop_front();
        n_checks++;
        if (int'(item[W-1 -: 32]) != cyc ||
            phase !== phase_t'(item[IDX_W+LW +: 2]) ||
            active_ch !== item[LW +: IDX_W] ||
            lights_bits !== item[LW-1:0]) begin
          n_fail++;
          $display("FAIL state cyc=%0d (due %0d): phase=%0d active=%0d lights=%h, required phase=%0d active=%0d lights=%h",
                   cyc, item[W-1 -: 32], phase, active_ch, lights_bits,
                   item[IDX_W+LW +: 2], item[LW +: IDX_W], item[LW-1:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 0, 1};

    // 1: single-cycle request on ch1 -> green 3, yellow 2, then rest in red
    do_reset("reset_s1");
    step(3'b010, 1'b0, GREEN, 1);
    step(3'b000, 1'b0, GREEN, 1);
    step(3'b000, 1'b0, GREEN, 1);
    step(3'b000, 1'b0, YELLOW, 1);
    step(3'b000, 1'b0, YELLOW, 1);
    for (int i = 0; i < 5; i++) step(3'b000, 1'b0, ALL_RED, 1);

    // 2: lone held request on ch2 keeps green indefinitely
    do_reset("reset_s2");
    for (int i = 0; i < 30; i++) step(3'b100, 1'b0, GREEN, 2);

    // 3: competitor preempts at GREEN_MAX; then own-low plus competitor
    do_reset("reset_s3");
    step(3'b100, 1'b0, GREEN, 2);
    step(3'b100, 1'b0, GREEN, 2);
    for (int i = 0; i < 3; i++) step(3'b101, 1'b0, GREEN, 2);
    step(3'b101, 1'b0, YELLOW, 2);
    step(3'b101, 1'b0, YELLOW, 2);
    step(3'b101, 1'b0, ALL_RED, 2);
    step(3'b101, 1'b0, GREEN, 0);
    step(3'b100, 1'b0, GREEN, 0);
    step(3'b100, 1'b0, GREEN, 0);
    step(3'b100, 1'b0, YELLOW, 0);
    step(3'b100, 1'b0, YELLOW, 0);
    step(3'b100, 1'b0, ALL_RED, 0);
    step(3'b100, 1'b0, GREEN, 2);

    // 4: all requesting -> round robin 0,1,2,0,1 with an 8-cycle period
    do_reset("reset_s4");
    for (int k = 0; k < 5; k++) begin
      for (int g = 0; g < 5; g++) step(3'b111, 1'b0, GREEN, order[k]);
      for (int y = 0; y < 2; y++) step(3'b111, 1'b0, YELLOW, order[k]);
      step(3'b111, 1'b0, ALL_RED, order[k]);
    end

    // 5: force_red cuts green short, cannot shorten yellow, blocks grants;
    //    on release ch1 is found from ptr=2 by wrap
    do_reset("reset_s5");
    step(3'b010, 1'b0, GREEN, 1);
    step(3'b010, 1'b1, YELLOW, 1);
    step(3'b010, 1'b1, YELLOW, 1);
    for (int i = 0; i < 9; i++) step(3'b010, 1'b1, ALL_RED, 1);
    step(3'b010, 1'b0, GREEN, 1);
    step(3'b010, 1'b0, GREEN, 1);

    // 6: async reset mid-yellow, then first grant from ptr=0
    do_reset("reset_s6");
    step(3'b001, 1'b0, GREEN, 0);
    step(3'b000, 1'b0, GREEN, 0);
    step(3'b000, 1'b0, GREEN, 0);
    step(3'b000, 1'b0, YELLOW, 0);
    do_reset("reset_mid_yellow");
    step(3'b110, 1'b0, GREEN, 1);
    step(3'b110, 1'b0, GREEN, 1);

    // Drain the scoreboard
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
